dmem_req_ctrl: RTL and testbench

//  Memory-stage data access controller directly downstream of the data-side MMU translation path.

---
 rtl/sirius_mem_pkg.sv | 25 ++
 rtl/dmem_lane_gen.sv | 41 ++++
 rtl/dmem_req_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sirius_mem_pkg.sv
// Shared definitions for the data-memory request path: exception codes,
// access-size encoding and the request controller state type.
package sirius_mem_pkg;

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_gen.sv
// Combinational byte-lane generator: turns access size, low address bits and
// LSB-aligned store data into byte enables, lane-replicated data and a misalignment flag.
module dmem_lane_gen
    import sirius_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mem_size_e             size,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     wdata_aligned,
    output logic                  misaligned
);

    localparam int STRB_W = DATA_W / 8;

    // The reserved size encoding falls into the default arm and behaves as a word.
    always_comb begin
        wstrb         = '1;
        wdata_aligned = wdata;
        misaligned    = 1'b0;
        case (size)
            SZ_BYTE: begin
                wstrb         = STRB_W'(1) << addr_lo;
                wdata_aligned = {STRB_W{wdata[7:0]}};
            end
            SZ_HALF: begin
                wstrb         = STRB_W'(3) << addr_lo;
                wdata_aligned = {(DATA_W/16){wdata[15:0]}};
                misaligned    = addr_lo[0];
            end
            default: begin
                wstrb         = '1;
                wdata_aligned = wdata;
                misaligned    = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Memory-stage data access controller: prioritised address/TLB exceptions, one outstanding
// bus request, pipeline stall until the response. Define DMEM_PERF_CNT_EN for perf counters.
module dmem_req_ctrl
    import sirius_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic [ADDR_W-1:0]     req_vaddr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     daddr_psy,
    input  logic                  data_uncached,
    input  logic                  data_miss,
    input  logic                  data_tlb_invalid,
    input  logic                  data_illegal,
    input  logic                  data_dirty,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  exc_valid,
    output logic [4:0]            exc_code,
    output logic                  exc_refill,
    output logic [ADDR_W-1:0]     exc_badvaddr,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_we,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [1:0]            bus_size,
    output logic                  bus_uncached,
`ifdef DMEM_PERF_CNT_EN
    output logic [31:0]           perf_tlb_exc,
    output logic [31:0]           perf_uncached,
`endif
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int STRB_W = DATA_W / 8;

    dmem_state_e         state_q, state_d;
    logic                exc_valid_q, exc_valid_d;
    logic [4:0]          exc_code_q, exc_code_d;
    logic                exc_refill_q, exc_refill_d;
    logic [ADDR_W-1:0]   exc_badvaddr_q, exc_badvaddr_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    mem_size_e           size_q, size_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                uncached_q, uncached_d;

    logic [STRB_W-1:0]   lane_strb;
    logic [DATA_W-1:0]   lane_wdata;
    logic                lane_misaligned;
    logic                accept;
    logic                exc_hit;
    logic [4:0]          exc_code_n;
    logic                exc_refill_n;

    dmem_lane_gen #(
        .DATA_W (DATA_W)
    ) u_lane_gen (
        .size          (mem_size_e'(req_size)),
        .addr_lo       (req_vaddr[1:0]),
        .wdata         (req_wdata),
        .wstrb         (lane_strb),
        .wdata_aligned (lane_wdata),
        .misaligned    (lane_misaligned)
    );

    // Reset is folded in so that stall reads 0 while reset is held.
    assign accept = ~rst & (state_q == ST_IDLE) & req_valid & ~flush;

    // Fixed priority: alignment/illegal, refill miss, invalid entry, then write to clean page.
    always_comb begin
        exc_hit      = 1'b1;
        exc_code_n   = 5'd0;
        exc_refill_n = 1'b0;
        if (lane_misaligned || data_illegal) begin
            exc_code_n = req_we ? EXC_ADES : EXC_ADEL;
        end else if (data_miss) begin
            exc_code_n   = req_we ? EXC_TLBS : EXC_TLBL;
            exc_refill_n = 1'b1;
        end else if (data_tlb_invalid) begin
            exc_code_n = req_we ? EXC_TLBS : EXC_TLBL;
        end else if (req_we && !data_dirty) begin
            exc_code_n = EXC_MOD;
        end else begin
            exc_hit = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        exc_valid_d    = 1'b0;
        exc_code_d     = exc_code_q;
        exc_refill_d   = exc_refill_q;
        exc_badvaddr_d = exc_badvaddr_q;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        addr_d         = addr_q;
        we_d           = we_q;
        size_d         = size_q;
        strb_d         = strb_q;
        wdata_d        = wdata_q;
        uncached_d     = uncached_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && exc_hit) begin
                    exc_valid_d    = 1'b1;
                    exc_code_d     = exc_code_n;
                    exc_refill_d   = exc_refill_n;
                    exc_badvaddr_d = req_vaddr;
                end else if (accept) begin
                    addr_d     = daddr_psy;
                    we_d       = req_we;
                    size_d     = (req_size == SZ_RSVD) ? SZ_WORD : mem_size_e'(req_size);
                    strb_d     = req_we ? lane_strb : '0;
                    wdata_d    = req_we ? lane_wdata : '0;
                    uncached_d = data_uncached;
                    state_d    = ST_REQ;
                end
            end
            // A flush that coincides with bus_ready is too late: the bus owns it, so drain.
            ST_REQ: begin
                if (flush) begin
                    state_d = bus_ready ? ST_DRAIN : ST_IDLE;
                end else if (bus_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = ~flush;
                    resp_rdata_d = bus_rdata;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            exc_valid_q    <= 1'b0;
            exc_code_q     <= 5'd0;
            exc_refill_q   <= 1'b0;
            exc_badvaddr_q <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            size_q         <= SZ_BYTE;
            strb_q         <= '0;
            wdata_q        <= '0;
            uncached_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            exc_valid_q    <= exc_valid_d;
            exc_code_q     <= exc_code_d;
            exc_refill_q   <= exc_refill_d;
            exc_badvaddr_q <= exc_badvaddr_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            size_q         <= size_d;
            strb_q         <= strb_d;
            wdata_q        <= wdata_d;
            uncached_q     <= uncached_d;
        end
    end

    assign stall        = (state_q != ST_IDLE) | (accept & ~exc_hit);
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_refill   = exc_refill_q;
    assign exc_badvaddr = exc_badvaddr_q;
    assign bus_valid    = (state_q == ST_REQ);
    assign bus_addr     = addr_q;
    assign bus_we       = we_q;
    assign bus_wstrb    = strb_q;
    assign bus_wdata    = wdata_q;
    assign bus_size     = size_q;
    assign bus_uncached = uncached_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_tlb_q, perf_tlb_d;
    logic [31:0] perf_unc_q, perf_unc_d;
    logic        tlb_exc_fire;

    always_comb begin
        tlb_exc_fire = accept & exc_hit &
                       ((exc_code_n == EXC_MOD) | (exc_code_n == EXC_TLBL) | (exc_code_n == EXC_TLBS));
        perf_tlb_d   = perf_tlb_q + 32'(tlb_exc_fire);
        perf_unc_d   = perf_unc_q + 32'(bus_valid & bus_ready & uncached_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_tlb_q <= '0;
            perf_unc_q <= '0;
        end else begin
            perf_tlb_q <= perf_tlb_d;
            perf_unc_q <= perf_unc_d;
        end
    end

    assign perf_tlb_exc  = perf_tlb_q;
    assign perf_uncached = perf_unc_q;
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: hand-written vector table, reset/flush
// sequences and randomized transactions against a cycle-timeline reference model.
module tb_dmem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, flush;
    logic [1:0]  req_size;
    logic [31:0] req_vaddr, req_wdata, daddr_psy;
    logic        data_uncached, data_miss, data_tlb_invalid, data_illegal, data_dirty;
    logic        stall, resp_valid, exc_valid, exc_refill;
    logic [31:0] resp_rdata, exc_badvaddr;
    logic [4:0]  exc_code;
    logic        bus_valid, bus_ready, bus_we, bus_uncached, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic [1:0]  bus_size;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    dmem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_vaddr(req_vaddr), .req_wdata(req_wdata), .flush(flush),
        .daddr_psy(daddr_psy), .data_uncached(data_uncached), .data_miss(data_miss),
        .data_tlb_invalid(data_tlb_invalid), .data_illegal(data_illegal), .data_dirty(data_dirty),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_refill(exc_refill),
        .exc_badvaddr(exc_badvaddr),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_size(bus_size),
        .bus_uncached(bus_uncached), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] vaddr, wdata, paddr, rdata;
        logic        unc, miss, inv, ill, dirty, hold;
        int          readyDly, rvDly, flushCyc;
        logic        expExc;
        logic [4:0]  expCode;
        logic        expRefill;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic [31:0] vaddr, logic [31:0] wdata,
                                logic [31:0] paddr, logic unc, logic miss, logic inv, logic ill,
                                logic dirty, int readyDly, int rvDly, int flushCyc, logic [31:0] rdata,
                                logic expExc, logic [4:0] expCode, logic expRefill,
                                logic [3:0] expStrb, logic [31:0] expWdata);
        vec_t v;
        v.we = we; v.size = size; v.vaddr = vaddr; v.wdata = wdata; v.paddr = paddr;
        v.unc = unc; v.miss = miss; v.inv = inv; v.ill = ill; v.dirty = dirty; v.hold = 1'b0;
        v.readyDly = readyDly; v.rvDly = rvDly; v.flushCyc = flushCyc; v.rdata = rdata;
        v.expExc = expExc; v.expCode = expCode; v.expRefill = expRefill;
        v.expStrb = expStrb; v.expWdata = expWdata;
        return v;
    endfunction

    // Expected exception/lane results from the access rules using plain arithmetic.
    function automatic vec_t refModel(vec_t vin);
        vec_t v = vin;
        int   off = int'(v.vaddr % 32'd4);
        int   sz  = (v.size == 2'd3) ? 2 : int'(v.size);
        bit   mis = (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
        v.expExc = 1'b1;
        v.expRefill = 1'b0;
        if (mis || v.ill)                v.expCode = v.we ? 5'd5 : 5'd4;
        else if (v.miss) begin           v.expCode = v.we ? 5'd3 : 5'd2; v.expRefill = 1'b1; end
        else if (v.inv)                  v.expCode = v.we ? 5'd3 : 5'd2;
        else if (v.we && !v.dirty)       v.expCode = 5'd1;
        else begin                       v.expCode = 5'd0; v.expExc = 1'b0; end
        if (!v.we)        v.expStrb = 4'd0;
        else if (sz == 0) v.expStrb = 4'(1 << off);
        else if (sz == 1) v.expStrb = 4'(3 << off);
        else              v.expStrb = 4'hF;
        if (sz == 0)      v.expWdata = (v.wdata & 32'hFF) * 32'h0101_0101;
        else if (sz == 1) v.expWdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
        else              v.expWdata = v.wdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left one time unit after a rising edge; every cycle is bounded.
    task automatic applyStimulus(input vec_t v);
        int sz        = (v.size == 2'd3) ? 2 : int'(v.size);
        int readyCyc  = 1 + v.readyDly;
        int rvCyc     = readyCyc + v.rvDly;
        bit idleFlush = (v.flushCyc == 0);
        bit flushReq  = (v.flushCyc >= 1) && (v.flushCyc < readyCyc);
        bit busActive = !v.expExc && !idleFlush;
        int lastCyc   = (!busActive) ? 2 : (flushReq ? v.flushCyc + 1 : rvCyc + 2);
        for (int cyc = 0; cyc <= lastCyc; cyc++) begin
            bit eStall, eBv, eResp, eExc;
            if (!busActive)    eStall = 1'b0;
            else if (flushReq) eStall = (cyc <= v.flushCyc);
            else               eStall = (cyc <= rvCyc);
            eBv   = busActive && cyc >= 1 && cyc <= (flushReq ? v.flushCyc : readyCyc);
            eResp = busActive && v.flushCyc < 0 && cyc == rvCyc + 1;
            eExc  = v.expExc && !idleFlush && cyc == 1;
            if (cyc == 0) begin
                req_valid = 1'b1; req_we = v.we; req_size = v.size; req_vaddr = v.vaddr;
                req_wdata = v.wdata; daddr_psy = v.paddr; data_uncached = v.unc;
                data_miss = v.miss; data_tlb_invalid = v.inv; data_illegal = v.ill;
                data_dirty = v.dirty;
            end else begin
                req_valid = v.hold && eStall;
                req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
                req_vaddr = $urandom; req_wdata = $urandom; daddr_psy = $urandom;
                data_uncached = 1'($urandom_range(0, 1)); data_miss = 1'($urandom_range(0, 1));
                data_tlb_invalid = 1'($urandom_range(0, 1)); data_illegal = 1'($urandom_range(0, 1));
                data_dirty = 1'($urandom_range(0, 1));
            end
            flush      = (cyc == v.flushCyc);
            bus_ready  = busActive && !flushReq && cyc == readyCyc;
            bus_rvalid = busActive && !flushReq && cyc == rvCyc;
            bus_rdata  = bus_rvalid ? v.rdata : $urandom;
            @(negedge clk);
            checkOutput("stall", 32'(stall), 32'(eStall));
            checkOutput("bus_valid", 32'(bus_valid), 32'(eBv));
            if (eBv) begin
                checkOutput("bus_addr", bus_addr, v.paddr);
                checkOutput("bus_we", 32'(bus_we), 32'(v.we));
                checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(v.expStrb));
                checkOutput("bus_size", 32'(bus_size), 32'(sz));
                checkOutput("bus_uncached", 32'(bus_uncached), 32'(v.unc));
                if (v.we) checkOutput("bus_wdata", bus_wdata, v.expWdata);
            end
            checkOutput("resp_valid", 32'(resp_valid), 32'(eResp));
            if (eResp) checkOutput("resp_rdata", resp_rdata, v.rdata);
            checkOutput("exc_valid", 32'(exc_valid), 32'(eExc));
            if (eExc) begin
                checkOutput("exc_code", 32'(exc_code), 32'(v.expCode));
                checkOutput("exc_refill", 32'(exc_refill), 32'(v.expRefill));
                checkOutput("exc_badvaddr", exc_badvaddr, v.vaddr);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0; flush = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_vaddr = '0;
        req_wdata = '0; flush = 1'b0; daddr_psy = '0; data_uncached = 1'b0; data_miss = 1'b0;
        data_tlb_invalid = 1'b0; data_illegal = 1'b0; data_dirty = 1'b0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        // Table: expected values worked out by hand from the access rules.
        tbl.push_back(mk(0, 2, 32'h8000_0010, 32'h0,         32'h0000_0010, 1, 0, 0, 0, 0, 0, 2, -1, 32'hDEAD_BEEF, 0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0040_0003, 32'h0000_00A5, 32'h0100_0003, 0, 0, 0, 0, 1, 1, 1, -1, 32'h0,          0, 0, 0, 4'h8, 32'hA5A5_A5A5));
        tbl.push_back(mk(0, 1, 32'h0040_0001, 32'h0,         32'h0,         0, 1, 0, 0, 1, 0, 1, -1, 32'h0,          1, 4, 0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 2, 32'h0040_1000, 32'h1122_3344, 32'h0,         0, 1, 0, 0, 1, 0, 1, -1, 32'h0,          1, 3, 1, 4'h0, 32'h0));
        tbl.push_back(mk(1, 2, 32'h0040_1000, 32'h1122_3344, 32'h0,         0, 0, 1, 0, 1, 0, 1, -1, 32'h0,          1, 3, 0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 2, 32'h0040_1000, 32'h1122_3344, 32'h0,         0, 0, 0, 0, 0, 0, 1, -1, 32'h0,          1, 1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_3002, 0, 0, 0, 0, 1, 0, 1, -1, 32'h0,          0, 0, 0, 4'hC, 32'h1234_1234));
        tbl.push_back(mk(1, 2, 32'h0000_1006, 32'h0,         32'h0,         0, 0, 0, 0, 1, 0, 1, -1, 32'h0,          1, 5, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0007, 32'h0,         32'h0,         0, 1, 0, 0, 0, 0, 1, -1, 32'h0,          1, 2, 1, 4'h0, 32'h0));
        tbl.push_back(mk(0, 2, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 1, 0, 0, 0, 1, -1, 32'h0,          1, 2, 0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 3, 32'h0000_0200, 32'hCAFE_F00D, 32'h0000_0A00, 0, 0, 0, 0, 1, 0, 2, -1, 32'h0,          0, 0, 0, 4'hF, 32'hCAFE_F00D));
        tbl.push_back(mk(0, 2, 32'h0000_0300, 32'h0,         32'h0,         0, 1, 0, 1, 0, 0, 1, -1, 32'h0,          1, 4, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 2, 32'h0000_0040, 32'h0,         32'h0000_0040, 0, 0, 0, 0, 0, 0, 3,  2, 32'h0000_0055, 0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 2, 32'h0000_0080, 32'h0F0F_0F0F, 32'h0000_0180, 0, 0, 0, 0, 1, 3, 1,  2, 32'h0,          0, 0, 0, 4'hF, 32'h0F0F_0F0F));
        tbl.push_back(mk(0, 2, 32'h0000_00C0, 32'h0,         32'h0000_00C0, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0,          0, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0000_0041, 32'h0000_003C, 32'h0000_0141, 1, 0, 0, 0, 1, 2, 2, -1, 32'h1234_5678, 0, 0, 0, 4'h2, 32'h3C3C_3C3C));
        tbl.push_back(mk(1, 1, 32'h0000_0001, 32'h0000_ABCD, 32'h0,         0, 1, 0, 0, 1, 0, 1, -1, 32'h0,          1, 5, 0, 4'h0, 32'h0));

        #12;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_bus_valid", 32'(bus_valid), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_exc_valid", 32'(exc_valid), 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

        $display("[TB] asynchronous reset while a request is pending");
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_vaddr = 32'h8000_0010;
        daddr_psy = 32'h0000_0010; data_uncached = 1'b1; data_miss = 1'b0;
        data_tlb_invalid = 1'b0; data_illegal = 1'b0; data_dirty = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_bus_valid", 32'(bus_valid), 32'd1);
        checkOutput("pre_rst_stall", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_bus_valid", 32'(bus_valid), 32'd0);
        checkOutput("async_rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(tbl[0]);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 200; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.size = 2'($urandom_range(0, 3));
            v.vaddr = $urandom;
            if ($urandom_range(0, 1) == 1) v.vaddr[1:0] = 2'b00;
            v.wdata = $urandom; v.paddr = $urandom; v.rdata = $urandom;
            v.unc = 1'($urandom_range(0, 1));
            v.miss = ($urandom_range(0, 7) == 0);
            v.inv = ($urandom_range(0, 7) == 0);
            v.ill = ($urandom_range(0, 7) == 0);
            v.dirty = ($urandom_range(0, 3) != 0);
            v.hold = 1'($urandom_range(0, 1));
            v.readyDly = int'($urandom_range(0, 3));
            v.rvDly = int'($urandom_range(1, 4));
            v = refModel(v);
            if ($urandom_range(0, 4) == 0)
                v.flushCyc = v.expExc ? 0 : int'($urandom_range(0, 1 + v.readyDly + v.rvDly));
            else
                v.flushCyc = -1;
            applyStimulus(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
